mii_tx_sm: RTL and testbench

//  64-bit MII transmit framer: takes packet beats on a valid/ready stream and emits lane-mapped

---
 rtl/mii_pkg.sv | 33 +++
 rtl/mii_tail_encoder.sv | 19 +
 rtl/mii_tx_sm.sv | 107 ++++++++++
 tb/tb_mii_tx_sm.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mii_pkg.sv
// Shared MII code constants, canned bus words and framer state encoding.
package mii_pkg;
  localparam logic [7:0] MII_IDLE     = 8'h07;
  localparam logic [7:0] MII_START    = 8'hFB;
  localparam logic [7:0] MII_TERM     = 8'hFD;
  localparam logic [7:0] MII_ERROR    = 8'hFE;
  localparam logic [7:0] MII_PREAMBLE = 8'h55;
  localparam logic [7:0] MII_SFD      = 8'hD5;

  localparam logic [63:0] IDLE_WORD  = {8{MII_IDLE}};
  localparam logic [63:0] START_WORD = {MII_SFD, {6{MII_PREAMBLE}}, MII_START};
  localparam logic [63:0] ERROR_WORD = {8{MII_ERROR}};
  localparam logic [63:0] TERM_WORD  = {{7{MII_IDLE}}, MII_TERM};

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_TERM    = 3'd3,
    ST_IPG     = 3'd4
  } mii_state_e;

  // Number of contiguous valid lanes counted from lane 0; the first zero ends the run.
  function automatic logic [3:0] keep_len(input logic [7:0] keep);
    logic stop;
    keep_len = 4'd0;
    stop     = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (!keep[i])   stop = 1'b1;
      else if (!stop) keep_len = keep_len + 4'd1;
    end
  endfunction
endpackage

// File: rtl/mii_tail_encoder.sv
// Builds the TERM-bearing last word: lanes below n keep data, lane n is TERM, lanes above are IDLE.
module mii_tail_encoder
  import mii_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [3:0]            n,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [7:0]            ctrl_out
);
  localparam int NUM_LANES = DATA_WIDTH / 8;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign data_out[8*i +: 8] = (4'(i) < n)  ? data[8*i +: 8] :
                                (4'(i) == n) ? MII_TERM : MII_IDLE;
    assign ctrl_out[i]        = (4'(i) >= n);
  end
endmodule

// File: rtl/mii_tx_sm.sv
// 64-bit MII transmit framer: stream beats in, START/preamble/payload/TERM/IDLE words out,
// with a programmable number of idle words after each frame.
module mii_tx_sm
  import mii_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int IPG_WORDS  = 1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic [7:0]            s_tkeep,
  input  logic                  s_tlast,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  output logic [DATA_WIDTH-1:0] mii_data,
  output logic [7:0]            mii_ctrl,
  output logic [CNT_WIDTH-1:0]  tx_frames,
  output logic [CNT_WIDTH-1:0]  tx_underruns
);
  localparam logic [3:0] IPG_LOAD = 4'(IPG_WORDS);

  mii_state_e            state, state_nxt;
  logic [3:0]            ipg_cnt, ipg_nxt;
  logic [DATA_WIDTH-1:0] data_nxt, tail_data;
  logic [7:0]            ctrl_nxt, tail_ctrl;
  logic [3:0]            last_n;
  logic                  frame_inc, under_inc;

  assign s_tready = (state == ST_PAYLOAD);
  assign last_n   = keep_len(s_tkeep);

  mii_tail_encoder #(.DATA_WIDTH(DATA_WIDTH)) u_tail (
    .data     (s_tdata),
    .n        (last_n),
    .data_out (tail_data),
    .ctrl_out (tail_ctrl)
  );

  always_comb begin
    state_nxt = state;
    ipg_nxt   = ipg_cnt;
    data_nxt  = IDLE_WORD;
    ctrl_nxt  = 8'hFF;
    frame_inc = 1'b0;
    under_inc = 1'b0;
    case (state)
      ST_IDLE: begin
        if (s_tvalid) state_nxt = ST_START;
      end
      ST_START: begin
        data_nxt  = START_WORD;
        ctrl_nxt  = 8'h01;
        state_nxt = ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        if (!s_tvalid) begin
          data_nxt  = ERROR_WORD;
          under_inc = 1'b1;
        end else if (!s_tlast || last_n == 4'd8) begin
          data_nxt = s_tdata;
          ctrl_nxt = 8'h00;
          if (s_tlast) state_nxt = ST_TERM;
        end else begin
          // TERM fits inside the last beat: no separate TERM word
          data_nxt  = tail_data;
          ctrl_nxt  = tail_ctrl;
          frame_inc = 1'b1;
          ipg_nxt   = IPG_LOAD;
          if (IPG_WORDS > 0) state_nxt = ST_IPG;
          else               state_nxt = ST_IDLE;
        end
      end
      ST_TERM: begin
        data_nxt  = TERM_WORD;
        frame_inc = 1'b1;
        ipg_nxt   = IPG_LOAD;
        if (IPG_WORDS > 0) state_nxt = ST_IPG;
        else               state_nxt = ST_IDLE;
      end
      ST_IPG: begin
        ipg_nxt = ipg_cnt - 4'd1;
        if (ipg_cnt <= 4'd1) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      ipg_cnt      <= 4'd0;
      mii_data     <= IDLE_WORD;
      mii_ctrl     <= 8'hFF;
      tx_frames    <= '0;
      tx_underruns <= '0;
    end else begin
      state        <= state_nxt;
      ipg_cnt      <= ipg_nxt;
      mii_data     <= data_nxt;
      mii_ctrl     <= ctrl_nxt;
      tx_frames    <= tx_frames + CNT_WIDTH'(frame_inc);
      tx_underruns <= tx_underruns + CNT_WIDTH'(under_inc);
    end
  end
endmodule

// File: tb/tb_mii_tx_sm.sv
// Bench for mii_tx_sm: frame-level model builds the expected word stream, a negedge
// process checks bus, ready and counters each cycle; literal checks pin the model.
module tb_mii_tx_sm;
  localparam int IPG = 2;
  localparam int CW  = 4;
  localparam logic [63:0] IDLE_W  = {8{8'h07}};
  localparam logic [63:0] START_W = {8'hD5, {6{8'h55}}, 8'hFB};
  localparam logic [63:0] TERM_W  = {{7{8'h07}}, 8'hFD};
  localparam logic [63:0] ERR_W   = {8{8'hFE}};

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [63:0]   s_tdata = '0;
  logic [7:0]    s_tkeep = '0;
  logic          s_tlast = 1'b0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic [63:0]   mii_data;
  logic [7:0]    mii_ctrl;
  logic [CW-1:0] tx_frames, tx_underruns;

  always #5 clk = ~clk;

  mii_tx_sm #(.DATA_WIDTH(64), .IPG_WORDS(IPG), .CNT_WIDTH(CW)) u_dut (
    .clk (clk), .rst (rst),
    .s_tdata (s_tdata), .s_tkeep (s_tkeep), .s_tlast (s_tlast),
    .s_tvalid (s_tvalid), .s_tready (s_tready),
    .mii_data (mii_data), .mii_ctrl (mii_ctrl),
    .tx_frames (tx_frames), .tx_underruns (tx_underruns)
  );

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  c;
    logic        rdy;
    logic        start;
    logic        term;
    logic        err;
  } exp_t;

  exp_t        expq[$];
  logic [71:0] seen[$];
  int checks = 0, errors = 0;
  int exp_frames = 0, exp_under = 0, idle_run = 0, last_gap = -1;
  bit in_frame = 0, after_term = 0;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [63:0] d, input logic [7:0] c,
                              input logic rdy, input logic start, input logic term, input logic err);
    exp_t e;
    e.d = d; e.c = c; e.rdy = rdy; e.start = start; e.term = term; e.err = err;
    return e;
  endfunction

  // Frame byte k is seed+k; lanes past the valid count carry junk that must never reach the bus.
  function automatic logic [63:0] beat_word(input logic [7:0] seed, input int b, input int nv);
    logic [63:0] w;
    for (int i = 0; i < 8; i++)
      w[8*i +: 8] = (i < nv) ? 8'(int'(seed) + 8*b + i) : 8'hC3;
    return w;
  endfunction

  // Compare process: idle words fill gaps, every other word must be the next expected one.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      expq.delete();
      exp_frames = 0; exp_under = 0; idle_run = 0;
      in_frame = 0; after_term = 0;
    end
    if (mii_data === IDLE_W && mii_ctrl === 8'hFF) begin
      idle_run++;
      chk("ready_outside_payload", 72'(s_tready), 72'(0));
      if (in_frame) chk("idle_inside_frame", 72'(1), 72'(0));
    end else begin
      seen.push_back({mii_ctrl, mii_data});
      if (expq.size() == 0) begin
        chk("unexpected_word", {mii_ctrl, mii_data}, {8'hFF, IDLE_W});
      end else begin
        e = expq.pop_front();
        chk("bus_word", {mii_ctrl, mii_data}, {e.c, e.d});
        chk("ready_in_frame", 72'(s_tready), 72'(e.rdy));
        if (e.start) begin
          if (after_term) begin
            last_gap = idle_run;
            chk("ipg_min_gap", 72'(idle_run >= IPG + 1), 72'(1));
          end
          after_term = 0;
          in_frame   = 1;
        end
        if (e.term) begin exp_frames++; after_term = 1; in_frame = 0; end
        if (e.err)  exp_under++;
      end
      idle_run = 0;
    end
    chk("tx_frames",    72'(tx_frames),    72'(exp_frames % (1 << CW)));
    chk("tx_underruns", 72'(tx_underruns), 72'(exp_under  % (1 << CW)));
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (s_tready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    chk("ready_timeout", 72'(s_tready), 72'(1));
  endtask

  // Pushes the frame's expected words, then drives it; drop_beat>0 idles valid one cycle before that beat.
  task automatic send_frame(input int len, input logic [7:0] seed, input int drop_beat,
                            input bit hold, input logic [7:0] junk);
    int beats, nl;
    logic [63:0] tw;
    logic [7:0]  tc;
    beats = (len + 7) / 8;
    if (beats == 0) beats = 1;
    nl = len - 8 * (beats - 1);
    expq.push_back(mk(START_W, 8'h01, 1, 1, 0, 0));
    for (int b = 0; b < beats; b++) begin
      if (b == drop_beat && b > 0) expq.push_back(mk(ERR_W, 8'hFF, 1, 0, 0, 1));
      if (b < beats - 1) expq.push_back(mk(beat_word(seed, b, 8), 8'h00, 1, 0, 0, 0));
      else if (nl == 8) begin
        expq.push_back(mk(beat_word(seed, b, 8), 8'h00, 0, 0, 0, 0));
        expq.push_back(mk(TERM_W, 8'hFF, 0, 0, 1, 0));
      end else begin
        for (int i = 0; i < 8; i++) begin
          tw[8*i +: 8] = (i < nl) ? 8'(int'(seed) + 8*b + i) : (i == nl) ? 8'hFD : 8'h07;
          tc[i]        = (i >= nl);
        end
        expq.push_back(mk(tw, tc, 0, 0, 1, 0));
      end
    end
    for (int b = 0; b < beats; b++) begin
      if (b == drop_beat && b > 0) begin s_tvalid = 1'b0; @(posedge clk); #1; end
      s_tvalid = 1'b1;
      s_tlast  = (b == beats - 1);
      s_tdata  = beat_word(seed, b, (b == beats - 1) ? nl : 8);
      s_tkeep  = (b == beats - 1) ? (8'((1 << nl) - 1) | junk) : 8'h03;
      wait_ready();
      @(posedge clk); #1;
    end
    if (!hold) begin s_tvalid = 1'b0; s_tlast = 1'b0; end
  endtask

  // Reset lands on a posedge between two compare samples so the model flush lines up.
  task automatic do_reset();
    @(negedge clk); #1 rst = 1'b1;
    @(negedge clk); #1;
    chk("rst_bus_data", 72'(mii_data), 72'(IDLE_W));
    chk("rst_bus_ctrl", 72'(mii_ctrl), 72'(8'hFF));
    chk("rst_ready",    72'(s_tready), 72'(0));
    chk("rst_frames",   72'(tx_frames), 72'(0));
    chk("rst_underruns", 72'(tx_underruns), 72'(0));
    @(posedge clk); #1 rst = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("por_bus_data", 72'(mii_data), 72'(IDLE_W));
    chk("por_bus_ctrl", 72'(mii_ctrl), 72'(8'hFF));
    chk("por_ready",    72'(s_tready), 72'(0));
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // 16-byte frame, full last beat -> separate TERM word
    seen.delete();
    send_frame(16, 8'h10, -1, 0, 8'h00);
    repeat (8) @(posedge clk);
    #1;
    chk("t1_count", 72'(seen.size()), 72'(4));
    chk("t1_start", seen[0], {8'h01, 64'hD5555555555555FB});
    chk("t1_d0",    seen[1], {8'h00, 64'h1716151413121110});
    chk("t1_d1",    seen[2], {8'h00, 64'h1F1E1D1C1B1A1918});
    chk("t1_term",  seen[3], {8'hFF, 64'h07070707070707FD});
    chk("t1_frames", 72'(tx_frames), 72'(1));

    // 13-byte frame: TERM inside the last word
    seen.delete();
    send_frame(13, 8'h20, -1, 0, 8'h00);
    repeat (8) @(posedge clk);
    #1;
    chk("t2_count", 72'(seen.size()), 72'(3));
    chk("t2_tail",  seen[2], {8'hE0, 64'h0707FD2C2B2A2928});

    // Underrun before the third beat
    seen.delete();
    send_frame(24, 8'h30, 2, 0, 8'h00);
    repeat (8) @(posedge clk);
    #1;
    chk("t3_count", 72'(seen.size()), 72'(6));
    chk("t3_error", seen[3], {8'hFF, 64'hFEFEFEFEFEFEFEFE});
    chk("t3_underruns", 72'(tx_underruns), 72'(1));
    chk("t3_frames",    72'(tx_frames),    72'(3));

    // Back-to-back with valid held; second frame has non-contiguous keep 0xA7
    seen.delete();
    send_frame(8, 8'h50, -1, 1, 8'h00);
    send_frame(11, 8'h60, -1, 0, 8'hA0);
    repeat (8) @(posedge clk);
    #1;
    chk("t4_gap", 72'(last_gap), 72'(IPG + 1));
    chk("t4_count", 72'(seen.size()), 72'(6));
    chk("t4_tail",  seen[5], {8'hF8, 64'h07070707FD6A6968});
    chk("t4_frames", 72'(tx_frames), 72'(5));

    // Reset in the middle of a frame
    expq.push_back(mk(START_W, 8'h01, 1, 1, 0, 0));
    expq.push_back(mk(beat_word(8'h70, 0, 8), 8'h00, 1, 0, 0, 0));
    s_tvalid = 1'b1; s_tlast = 1'b0; s_tkeep = 8'hFF; s_tdata = beat_word(8'h70, 0, 8);
    wait_ready();
    @(posedge clk); #1;
    s_tvalid = 1'b0;
    do_reset();
    seen.delete();
    send_frame(8, 8'h80, -1, 0, 8'h00);
    repeat (8) @(posedge clk);
    #1;
    chk("t5_start", seen[0], {8'h01, 64'hD5555555555555FB});
    chk("t5_frames", 72'(tx_frames), 72'(1));

    // 17 empty frames wrap the 4-bit frame counter to 1
    do_reset();
    seen.delete();
    for (int f = 0; f < 17; f++) send_frame(0, 8'h00, -1, 0, 8'h00);
    repeat (8) @(posedge clk);
    #1;
    chk("t6_count", 72'(seen.size()), 72'(34));
    chk("t6_term",  seen[1], {8'hFF, 64'h07070707070707FD});
    chk("t6_wrap",  72'(tx_frames), 72'(1));
    chk("queue_drained", 72'(expq.size()), 72'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
